// File: rtl/counter_pkg.sv
// counter_pkg
// Shared definitions for the up/down counter family.
//   CNT_WRAP / CNT_SAT : values for the SATURATE parameter of counter_ud_mod
//   prescale_width()   : bit width of the prescaler phase counter
package counter_pkg;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    // At least one bit so a PRESCALE of 1 or 2 still yields a legal vector.
    function automatic int prescale_width(input int prescale);
        return (prescale <= 2) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/counter_ud_mod_if.sv
// counter_ud_mod_if
// Control/status bundle of one counter_ud_mod instance.
//   COUNT, UP, LOAD, CLR, COUNT_IN, OVF_CLR : controls into the counter
//   COUNT_OUT, TC, WRAP, OVF                : status out of the counter
// master = the controlling side, slave = the counter itself.
interface counter_ud_mod_if #(
    parameter int WIDTH = 8
);
    logic             COUNT;
    logic             UP;
    logic             LOAD;
    logic             CLR;
    logic [WIDTH-1:0] COUNT_IN;
    logic             OVF_CLR;
    logic [WIDTH-1:0] COUNT_OUT;
    logic             TC;
    logic             WRAP;
    logic             OVF;

    modport master (
        output COUNT, UP, LOAD, CLR, COUNT_IN, OVF_CLR,
        input  COUNT_OUT, TC, WRAP, OVF
    );

    modport slave (
        input  COUNT, UP, LOAD, CLR, COUNT_IN, OVF_CLR,
        output COUNT_OUT, TC, WRAP, OVF
    );
endinterface

// File: rtl/counter_prescale.sv
// counter_prescale
// Divides the count enable by PRESCALE: TICK fires on every PRESCALE-th
// cycle in which EN is high. The phase only advances while EN is high.
//   CLK      : rising-edge clock
//   RST      : asynchronous active-high reset (phase -> 0)
//   EN       : count enable
//   SYNC_CLR : synchronous phase restart (dominates EN)
//   TICK     : combinational, EN & phase at its last value
module counter_prescale
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic SYNC_CLR,
    output logic TICK
);

    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $error("counter_prescale: PRESCALE=%0d outside 1..65535", PRESCALE);
    end

    localparam int            PW       = prescale_width(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    // TICK does not look at SYNC_CLR; the parent gates its own use of it.
    assign TICK = EN & (pre_q == PRE_LAST);

    always_comb begin
        pre_d = pre_q;
        if (SYNC_CLR) begin
            pre_d = '0;
        end else if (TICK) begin
            pre_d = '0;
        end else if (EN) begin
            pre_d = pre_q + PW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/counter_ud_mod.sv
// counter_ud_mod
// Parametrised modulo-MODULUS up/down counter with load, clear, prescaled
// enable, wrap or saturate behaviour, cascade carry and overflow flags.
//   CLK       : rising-edge clock
//   RST       : asynchronous active-high reset
//   bus.COUNT     : count enable (goes through the prescaler)
//   bus.UP        : 1 = increment, 0 = decrement
//   bus.LOAD      : synchronous load of COUNT_IN (clamped to MODULUS-1)
//   bus.CLR       : synchronous clear, highest priority
//   bus.COUNT_IN  : load value
//   bus.OVF_CLR   : clears the sticky OVF flag
//   bus.COUNT_OUT : registered count
//   bus.TC        : combinational terminal count, feeds the next stage COUNT
//   bus.WRAP      : one-cycle registered pulse on an end event
//   bus.OVF       : sticky registered end-event flag
module counter_ud_mod
    import counter_pkg::*;
#(
    parameter int     WIDTH    = 8,
    parameter longint MODULUS  = 256,
    parameter int     SATURATE = CNT_WRAP,
    parameter int     PRESCALE = 1
) (
    input  logic             CLK,
    input  logic             RST,
    counter_ud_mod_if.slave  bus
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("counter_ud_mod: WIDTH=%0d outside 2..32", WIDTH);
    end
    if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $error("counter_ud_mod: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
    end
    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $error("counter_ud_mod: PRESCALE=%0d outside 1..65535", PRESCALE);
    end
    if (SATURATE != CNT_WRAP && SATURATE != CNT_SAT) begin : g_bad_mode
        $error("counter_ud_mod: SATURATE=%0d must be 0 or 1", SATURATE);
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             ovf_q;
    logic             ovf_d;

    logic             tick;
    logic             step_en;
    logic             at_end;
    logic             end_evt;

    // LOAD and CLR both restart the prescaler phase.
    counter_prescale #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (bus.COUNT),
        .SYNC_CLR (bus.CLR | bus.LOAD),
        .TICK     (tick)
    );

    // A tick is swallowed whenever CLR or LOAD owns the edge, which also
    // keeps TC low in those cycles so a cascaded stage never steps.
    assign step_en = tick & ~bus.CLR & ~bus.LOAD;
    assign at_end  = bus.UP ? (count_q == MAX_VAL) : (count_q == '0);
    assign end_evt = step_en & at_end;

    always_comb begin
        count_d = count_q;
        if (bus.CLR) begin
            count_d = '0;
        end else if (bus.LOAD) begin
            count_d = (bus.COUNT_IN > MAX_VAL) ? MAX_VAL : bus.COUNT_IN;
        end else if (step_en) begin
            if (at_end) begin
                // Saturate mode simply holds the end value.
                if (SATURATE == CNT_WRAP) begin
                    count_d = bus.UP ? '0 : MAX_VAL;
                end
            end else begin
                count_d = bus.UP ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
            end
        end
    end

    // A fresh end event wins over OVF_CLR in the same cycle.
    assign wrap_d = end_evt;
    assign ovf_d  = end_evt | (ovf_q & ~bus.OVF_CLR);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.COUNT_OUT = count_q;
    assign bus.TC        = end_evt;
    assign bus.WRAP      = wrap_q;
    assign bus.OVF       = ovf_q;

endmodule

// File: doc/counter_ud_mod.md
Name: counter_ud_mod

Overview:
Parametrised successor to the team's 8-bit loadable counter. Adds the following:
- configurable width and modulus
- up/down direction
- wrap or saturate mode
- enable prescaler
- cascade carry output and a sticky overflow flag

It is used as a general event/timebase counter in the datapath, and instances can be chained through TC.

Parameters:
WIDTH, 8, bit width of COUNT_IN/COUNT_OUT; legal range 2..32
MODULUS, 256, count range is 0..MODULUS-1; legal range 2..2**WIDTH
SATURATE, 0, 0 = wrap at the ends of the range; 1 = hold at the end value
PRESCALE, 1, number of COUNT-qualified cycles per count step; legal range 1..65535

Ports:
CLK  in  1  rising-edge clock
RST  in  1  asynchronous, active-high reset
COUNT  in  1  count enable
UP  in  1  direction: 1 = increment, 0 = decrement
LOAD  in  1  synchronous parallel load
CLR  in  1  synchronous clear to 0
COUNT_IN  in  WIDTH  load value
OVF_CLR  in  1  clears the sticky OVF flag
COUNT_OUT  out  WIDTH  registered count value
TC  out  1  combinational terminal-count carry
WRAP  out  1  registered one-cycle pulse for a wrap or saturation event
OVF  out  1  registered sticky flag for a wrap or saturation event

Behaviour:
- Reset: RST high asynchronously forces COUNT_OUT=0, the prescaler to 0, WRAP=0 and OVF=0. Outputs hold these values while RST is high. The first update occurs on the first rising edge after RST falls.
- Per-edge priority is CLR > LOAD > COUNT. Lower-priority inputs are ignored in that cycle.
- CLR: COUNT_OUT<=0 and prescaler<=0. WRAP is not pulsed.
- LOAD: COUNT_OUT<=COUNT_IN, or MODULUS-1 if COUNT_IN>=MODULUS (clamped). Prescaler<=0. WRAP is not pulsed.
- Prescaler tick: when COUNT=1, an internal counter pre advances 0..PRESCALE-1.
  - tick = COUNT & (pre==PRESCALE-1).
  - On tick, pre returns to 0.
  - With PRESCALE=1, tick=COUNT.
  - When COUNT=0, pre holds.
- Step on tick, UP=1:
  - If COUNT_OUT<MODULUS-1, COUNT_OUT+1.
  - If COUNT_OUT==MODULUS-1: becomes 0 when SATURATE=0; holds when SATURATE=1.
- Step on tick, UP=0:
  - If COUNT_OUT>0, COUNT_OUT-1.
  - If COUNT_OUT==0: becomes MODULUS-1 when SATURATE=0; holds at 0 when SATURATE=1.
- End event: a tick while COUNT_OUT is at the end value for the current direction (MODULUS-1 for up, 0 for down).
  - WRAP<=1 for exactly one cycle after the edge, in both modes.
  - OVF<=1 and remains set until cleared.
- OVF_CLR clears OVF on the edge. A simultaneous end event takes precedence, so OVF stays 1.
- TC = tick & at-end-value, combinational, with no register stage. It is connected to the COUNT input of the next stage for cascading. TC must not glitch-depend on LOAD or CLR: it is gated low whenever CLR or LOAD is high.
- Latency: COUNT_OUT updates one edge after the qualifying inputs. WRAP and OVF assert on that same edge.
- Direction change mid-count takes effect on the next tick. The prescaler phase is not reset by a change of UP.
- All arithmetic is unsigned, modulo the range [0, MODULUS-1]. No intermediate value may exceed WIDTH+1 bits.
- Elaboration errors are required for an illegal MODULUS or PRESCALE.

Decomposition:
- Shared package counter_pkg holds:
  - mode constants CNT_WRAP=0 and CNT_SAT=1
  - the clog2-based prescaler width function
- One sub-module, counter_prescale, with parameter PRESCALE and ports CLK, RST, EN, SYNC_CLR, TICK. It contains the pre counter and tick generation, and is instantiated once.

Test Plan:
1. Reset mid-count: count to 5, then assert RST off-edge -> COUNT_OUT=0, OVF=0 immediately (asynchronous) and held while RST is high.
2. Wrap up, WIDTH=8, MODULUS=10, PRESCALE=1, UP=1, COUNT=1 from 0 -> sequence 0..9 then 0. TC=1 only while 9 with COUNT=1. WRAP pulses one cycle after 9->0. OVF stays 1 until OVF_CLR.
3. Saturate down, SATURATE=1, LOAD COUNT_IN=2, UP=0 -> 2,1,0,0,0. WRAP pulses on each edge where it holds at 0. OVF=1.
4. Load clamp and priority, MODULUS=10:
   - LOAD=1, COUNT_IN=200, COUNT=1 -> COUNT_OUT=9 with no increment.
   - CLR=1 with LOAD=1 -> COUNT_OUT=0.
5. Prescaler, PRESCALE=3, COUNT=1 continuous -> COUNT_OUT steps every 3rd edge. Deasserting COUNT for 2 cycles delays the next step by 2 cycles. A LOAD restarts the 3-cycle phase.
6. Cascade: two instances, MODULUS=10, with low TC driving high COUNT. Run 25 ticks -> high=2, low=5. A direction switch to UP=0 at 25 counts down to 24 on the next tick.
